// File: rtl/hdmi_pix_out_pkg.sv
// hdmi_pix_out_pkg
// Shared definitions for the HDMI pixel output stage.
//   - state_t and the S_* state encodings of the alignment FSM
//   - default RGB width; the SOF marker sits one bit above the RGB word (bit DATA_W)
//   - default colour shown on DE pixels that have no valid data
package hdmi_pix_out_pkg;

  localparam int DEF_DATA_W = 24;

  localparam logic [DEF_DATA_W-1:0] DEF_ERR_COLOR = 24'hFF00FF;

  typedef logic [1:0] state_t;

  localparam state_t S_ALIGN   = 2'd0;
  localparam state_t S_WAIT_VS = 2'd1;
  localparam state_t S_STREAM  = 2'd2;

endpackage

// File: rtl/hdmi_pix_out_if.sv
// hdmi_pix_out_if
// Read side of the show-ahead (FWFT) frame FIFO feeding the pixel output stage.
//   fifo_data  [DATA_W:0]  head word, bit DATA_W = start-of-frame marker
//   fifo_empty             head not valid
//   fifo_rd                pop the head this cycle
// master = pixel output stage (pops), slave = FIFO (supplies the head).
interface hdmi_pix_out_if
  import hdmi_pix_out_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W:0] fifo_data;
  logic            fifo_empty;
  logic            fifo_rd;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd
  );

endinterface

// File: rtl/hdmi_pix_out_sat_counter.sv
// sat_counter
// Saturating up-counter used for the error statistics.
//   clk  in   clock
//   clr  in   synchronous clear, dominates inc
//   inc  in   add one this cycle (ignored once at all-ones)
//   q    out  count value, sticks at all-ones instead of wrapping
module sat_counter
  import hdmi_pix_out_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/hdmi_pix_out.sv
// hdmi_pix_out
// Pixel output stage between the video timing generator and the ADV7513 pins.
// Pops one RGB word per DE-active pixel from a show-ahead frame FIFO and registers
// it together with DE/HS/VS so all four pin groups leave one pix_clk after the inputs.
// Frame alignment follows the SOF marker bit; underflows and misplaced SOF words are
// counted in saturating counters.
// Ports:
//   pix_clk        in   pixel clock (only clock)
//   reset          in   synchronous active-high reset
//   de_in/hs_in/vs_in in video timing from the sync generator
//   fifo           if   FIFO read side (master modport)
//   HDMI_TX_D      out  registered pixel data
//   HDMI_TX_DE/HS/VS out timing delayed by one cycle
//   locked         out  1 while streaming frame data
//   underflow_cnt  out  DE pixels that found the FIFO empty while streaming
//   frame_err_cnt  out  SOF words found early or late
module hdmi_pix_out
  import hdmi_pix_out_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter logic            VS_ACT_HIGH = 1'b0,
  parameter logic            HS_ACT_HIGH = 1'b0,
  parameter logic [DATA_W-1:0] ERR_COLOR = DEF_ERR_COLOR,
  parameter int              CNT_W       = 16
) (
  input  logic              pix_clk,
  input  logic              reset,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  hdmi_pix_out_if.master    fifo,
  output logic [DATA_W-1:0] HDMI_TX_D,
  output logic              HDMI_TX_DE,
  output logic              HDMI_TX_HS,
  output logic              HDMI_TX_VS,
  output logic              locked,
  output logic [CNT_W-1:0]  underflow_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              first_px;
  logic              first_nxt;
  logic              vs_prev;
  logic              vs_act;
  logic              vs_edge;
  logic              first_eff;
  logic              head_sof;
  logic              rd;
  logic              uf_inc;
  logic              fe_inc;
  logic [DATA_W-1:0] d_nxt;

  // vs_prev holds "previous VS was active", so it resets to 0 (inactive).
  assign vs_act   = (vs_in == VS_ACT_HIGH);
  assign vs_edge  = vs_act && !vs_prev;
  assign head_sof = fifo.fifo_data[DATA_W];

  // A VS edge coinciding with a DE pixel counts before that pixel is judged,
  // so the pixel is treated as the first of the frame.
  assign first_eff = first_px || vs_edge;

  // Next-state, pop and next-pixel decision. Outside S_STREAM the block only
  // hunts for the SOF word (discarding stale data) and then waits for VS.
  always_comb begin
    state_nxt = state;
    first_nxt = first_px;
    rd        = 1'b0;
    uf_inc    = 1'b0;
    fe_inc    = 1'b0;
    d_nxt     = '0;
    case (state)
      S_ALIGN: begin
        if (!fifo.fifo_empty) begin
          if (head_sof) begin
            state_nxt = S_WAIT_VS;
          end else begin
            rd = 1'b1;
          end
        end
        if (de_in) begin
          d_nxt = ERR_COLOR;
        end
      end
      S_WAIT_VS: begin
        if (vs_edge) begin
          state_nxt = S_STREAM;
          first_nxt = 1'b1;
        end
        if (de_in) begin
          d_nxt = ERR_COLOR;
        end
      end
      S_STREAM: begin
        first_nxt = first_eff;
        if (de_in) begin
          if (fifo.fifo_empty) begin
            d_nxt     = ERR_COLOR;
            uf_inc    = 1'b1;
            state_nxt = S_ALIGN;
            first_nxt = 1'b0;
          end else if (first_eff && head_sof) begin
            rd        = 1'b1;
            d_nxt     = fifo.fifo_data[DATA_W-1:0];
            first_nxt = 1'b0;
          end else if (first_eff) begin
            // Late SOF: the frame start is not at the head, hunt for it.
            d_nxt     = ERR_COLOR;
            fe_inc    = 1'b1;
            state_nxt = S_ALIGN;
            first_nxt = 1'b0;
          end else if (head_sof) begin
            // Early SOF: the previous frame was short; keep the SOF for next VS.
            d_nxt     = ERR_COLOR;
            fe_inc    = 1'b1;
            state_nxt = S_WAIT_VS;
            first_nxt = 1'b0;
          end else begin
            rd    = 1'b1;
            d_nxt = fifo.fifo_data[DATA_W-1:0];
          end
        end
      end
      default: begin
        state_nxt = S_ALIGN;
        first_nxt = 1'b0;
      end
    endcase
  end

  // The pop strobe is combinational from the state, so it is also gated by
  // reset to keep the FIFO untouched while reset is held.
  assign fifo.fifo_rd = rd && !reset;

  assign locked = (state == S_STREAM);

  // State plus the single output register stage shared by data and timing.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      state      <= S_ALIGN;
      first_px   <= 1'b0;
      vs_prev    <= 1'b0;
      HDMI_TX_D  <= '0;
      HDMI_TX_DE <= 1'b0;
      HDMI_TX_HS <= ~HS_ACT_HIGH;
      HDMI_TX_VS <= ~VS_ACT_HIGH;
    end else begin
      state      <= state_nxt;
      first_px   <= first_nxt;
      vs_prev    <= vs_act;
      HDMI_TX_D  <= d_nxt;
      HDMI_TX_DE <= de_in;
      HDMI_TX_HS <= hs_in;
      HDMI_TX_VS <= vs_in;
    end
  end

  sat_counter #(.W(CNT_W)) u_underflow_cnt (
    .clk (pix_clk),
    .clr (reset),
    .inc (uf_inc),
    .q   (underflow_cnt)
  );

  sat_counter #(.W(CNT_W)) u_frame_err_cnt (
    .clk (pix_clk),
    .clr (reset),
    .inc (fe_inc),
    .q   (frame_err_cnt)
  );

endmodule

// File: tb/tb_hdmi_pix_out.sv
// tb_hdmi_pix_out
// Self-checking bench for hdmi_pix_out. The bench plays the FIFO (a queue of
// 25-bit words) and a small video timing generator, and predicts every output
// with a behavioural model of the alignment rules. Counters are built 4 bits
// wide so saturation is reachable in a short run.
module tb_hdmi_pix_out;

  localparam int          DW      = 24;
  localparam int          CW      = 4;
  localparam int          CNT_MAX = 15;
  localparam logic [23:0] ERR     = 24'hFF00FF;
  localparam int          H_ACT   = 8;
  localparam int          H_TOT   = 12;
  localparam int          V_TOT   = 6;
  localparam int          V_ACT   = 4;
  localparam int          PIX     = H_ACT * V_ACT;
  localparam int          M_SEEK   = 0;
  localparam int          M_WAIT   = 1;
  localparam int          M_STREAM = 2;

  logic          pix_clk = 1'b0;
  logic          reset;
  logic          de_in;
  logic          hs_in;
  logic          vs_in;
  logic [DW-1:0] HDMI_TX_D;
  logic          HDMI_TX_DE;
  logic          HDMI_TX_HS;
  logic          HDMI_TX_VS;
  logic          locked;
  logic [CW-1:0] underflow_cnt;
  logic [CW-1:0] frame_err_cnt;

  hdmi_pix_out_if #(.DATA_W(DW)) fif ();

  hdmi_pix_out #(
    .DATA_W      (DW),
    .VS_ACT_HIGH (1'b0),
    .HS_ACT_HIGH (1'b0),
    .ERR_COLOR   (ERR),
    .CNT_W       (CW)
  ) dut (
    .pix_clk       (pix_clk),
    .reset         (reset),
    .de_in         (de_in),
    .hs_in         (hs_in),
    .vs_in         (vs_in),
    .fifo          (fif.master),
    .HDMI_TX_D     (HDMI_TX_D),
    .HDMI_TX_DE    (HDMI_TX_DE),
    .HDMI_TX_HS    (HDMI_TX_HS),
    .HDMI_TX_VS    (HDMI_TX_VS),
    .locked        (locked),
    .underflow_cnt (underflow_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 pix_clk = ~pix_clk;

  int          checks = 0;
  int          errors = 0;
  int          pop_cnt = 0;
  logic [24:0] fifo_q[$];

  int   m_mode;
  logic m_first;
  logic m_prev_act;
  int   m_uf;
  int   m_fe;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One pixel clock: drive inputs, predict, check the pop strobe, then check
  // the registered outputs just after the edge and retire the predicted pop.
  task automatic applyStimulus(input logic rst, input logic de, input logic hs, input logic vs);
    logic        empty;
    logic [24:0] head;
    logic        exp_rd;
    logic [23:0] exp_d;
    logic        exp_de;
    logic        exp_hs;
    logic        exp_vs;
    logic        vs_act;
    logic        vs_edge;
    @(negedge pix_clk);
    reset = rst;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    empty = (fifo_q.size() == 0);
    head  = empty ? 25'($urandom) : fifo_q[0];
    fif.fifo_empty = empty;
    fif.fifo_data  = head;
    exp_rd  = 1'b0;
    exp_d   = '0;
    vs_act  = (vs == 1'b0);
    vs_edge = vs_act && !m_prev_act;
    if (rst) begin
      exp_de = 1'b0;
      exp_hs = 1'b1;
      exp_vs = 1'b1;
      m_mode = M_SEEK;
      m_first = 1'b0;
      m_prev_act = 1'b0;
      m_uf = 0;
      m_fe = 0;
    end else begin
      exp_de = de;
      exp_hs = hs;
      exp_vs = vs;
      if (m_mode == M_SEEK) begin
        if (de) exp_d = ERR;
        if (!empty && !head[24]) exp_rd = 1'b1;
        else if (!empty) m_mode = M_WAIT;
      end else if (m_mode == M_WAIT) begin
        if (de) exp_d = ERR;
        if (vs_edge) begin
          m_mode = M_STREAM;
          m_first = 1'b1;
        end
      end else begin
        if (vs_edge) m_first = 1'b1;
        if (de) begin
          if (empty) begin
            exp_d = ERR;
            if (m_uf < CNT_MAX) m_uf++;
            m_mode = M_SEEK;
          end else if (m_first && head[24]) begin
            exp_rd = 1'b1;
            exp_d = head[23:0];
            m_first = 1'b0;
          end else if (m_first) begin
            exp_d = ERR;
            if (m_fe < CNT_MAX) m_fe++;
            m_mode = M_SEEK;
          end else if (head[24]) begin
            exp_d = ERR;
            if (m_fe < CNT_MAX) m_fe++;
            m_mode = M_WAIT;
          end else begin
            exp_rd = 1'b1;
            exp_d = head[23:0];
          end
        end
      end
      m_prev_act = vs_act;
    end
    #1;
    checkOutput("fifo_rd", 32'(fif.fifo_rd), 32'(exp_rd));
    if (fif.fifo_rd === 1'b1) pop_cnt++;
    @(posedge pix_clk);
    #1;
    checkOutput("tx_d", 32'(HDMI_TX_D), 32'(exp_d));
    checkOutput("tx_de", 32'(HDMI_TX_DE), 32'(exp_de));
    checkOutput("tx_hs", 32'(HDMI_TX_HS), 32'(exp_hs));
    checkOutput("tx_vs", 32'(HDMI_TX_VS), 32'(exp_vs));
    checkOutput("locked", 32'(locked), 32'(m_mode == M_STREAM));
    checkOutput("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
    checkOutput("frame_err_cnt", 32'(frame_err_cnt), 32'(m_fe));
    if (exp_rd) void'(fifo_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic pixels(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic pushWord(input logic sof, input logic [23:0] d);
    fifo_q.push_back({sof, d});
  endtask

  // One frame of data: optional stale words, SOF word, then the rest of the pixels.
  task automatic pushFrame(input int short_by, input bit junk);
    if (junk) repeat ($urandom_range(1, 3)) pushWord(1'b0, 24'($urandom));
    pushWord(1'b1, 24'($urandom));
    repeat (PIX - 1 - short_by) pushWord(1'b0, 24'($urandom));
  endtask

  // Blank line, VS line, then V_ACT active lines; the following frame's data is
  // queued either at frame start or (late) after the active lines.
  task automatic runFrame(input int short_next, input bit junk_next, input bit late);
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (v == 0 && h == 0 && !late) pushFrame(short_next, junk_next);
        applyStimulus(1'b0, (v >= V_TOT - V_ACT) && (h < H_ACT), !(h == 9 || h == 10), !(v == 1));
      end
    end
    if (late) pushFrame(short_next, junk_next);
  endtask

  initial begin
    logic [23:0] last_word;
    int          snap_uf;
    int          snap_fe;
    reset = 1'b1;
    de_in = 1'b0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    fif.fifo_empty = 1'b1;
    fif.fifo_data  = '0;
    m_mode = M_SEEK;
    m_first = 1'b0;
    m_prev_act = 1'b0;
    m_uf = 0;
    m_fe = 0;

    // Reset held with DE high and a non-SOF word waiting.
    pushWord(1'b0, 24'hABCDEF);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_rd", 32'(fif.fifo_rd), 32'd0);
    checkOutput("rst_d", 32'(HDMI_TX_D), 32'd0);
    checkOutput("rst_hs_vs", 32'({HDMI_TX_HS, HDMI_TX_VS}), 32'd3);
    fifo_q.delete();

    // Two stale words discarded, then the SOF frame streams after VS.
    pushWord(1'b0, 24'($urandom));
    pushWord(1'b0, 24'($urandom));
    pushWord(1'b1, 24'h112233);
    pushWord(1'b0, 24'h445566);
    pop_cnt = 0;
    idle(4);
    checkOutput("junk_pops", 32'(pop_cnt), 32'd2);
    vsPulse();
    pixels(1);
    checkOutput("first_px", 32'(HDMI_TX_D), 32'h112233);
    pixels(1);
    checkOutput("second_px", 32'(HDMI_TX_D), 32'h445566);
    checkOutput("locked_on", 32'(locked), 32'd1);
    idle(1);

    // FIFO runs dry at pixel 5 of a line.
    pushWord(1'b1, 24'($urandom));
    repeat (4) pushWord(1'b0, 24'($urandom));
    vsPulse();
    pixels(6);
    checkOutput("uf_px", 32'(HDMI_TX_D), 32'(ERR));
    checkOutput("uf_cnt", 32'(underflow_cnt), 32'd1);
    checkOutput("uf_unlock", 32'(locked), 32'd0);
    pixels(2);
    idle(2);

    // Late SOF: first pixel after VS finds a non-SOF head.
    pushWord(1'b1, 24'($urandom));
    pushWord(1'b0, 24'($urandom));
    pushWord(1'b0, 24'($urandom));
    pushWord(1'b0, 24'($urandom));
    idle(2);
    vsPulse();
    pixels(2);
    idle(1);
    vsPulse();
    pop_cnt = 0;
    pixels(1);
    checkOutput("late_px", 32'(HDMI_TX_D), 32'(ERR));
    checkOutput("late_cnt", 32'(frame_err_cnt), 32'd1);
    checkOutput("late_nopop", 32'(pop_cnt), 32'd0);

    // Early SOF from a short frame, then clean streaming from that SOF.
    pushWord(1'b1, 24'($urandom));
    repeat (3) pushWord(1'b0, 24'($urandom));
    pushWord(1'b1, 24'($urandom));
    pushWord(1'b0, 24'($urandom));
    last_word = 24'($urandom);
    pushWord(1'b0, last_word);
    idle(5);
    vsPulse();
    pixels(5);
    checkOutput("early_cnt", 32'(frame_err_cnt), 32'd2);
    checkOutput("early_unlock", 32'(locked), 32'd0);
    idle(1);
    vsPulse();
    pixels(3);
    checkOutput("resync_px", 32'(HDMI_TX_D), 32'(last_word));
    checkOutput("resync_fe", 32'(frame_err_cnt), 32'd2);
    checkOutput("resync_uf", 32'(underflow_cnt), 32'd1);
    idle(1);

    // Random frame stream with short frames, stale words and late data.
    pushFrame(0, 1'b0);
    for (int f = 0; f < 60; f++) begin
      runFrame((($urandom % 4) == 0) ? int'($urandom_range(1, 10)) : 0,
               (($urandom % 5) == 0), (($urandom % 5) == 0));
    end

    // Back-to-back clean frames: one pop per active pixel, no new errors.
    fifo_q.delete();
    pushFrame(0, 1'b0);
    runFrame(0, 1'b0, 1'b0);
    snap_uf = m_uf;
    snap_fe = m_fe;
    for (int f = 0; f < 2; f++) begin
      pop_cnt = 0;
      runFrame(0, 1'b0, 1'b0);
      checkOutput("frame_pops", 32'(pop_cnt), 32'(PIX));
      checkOutput("frame_uf", 32'(underflow_cnt), 32'(snap_uf));
      checkOutput("frame_fe", 32'(frame_err_cnt), 32'(snap_fe));
    end

    // Drive both counters past all-ones.
    for (int i = 0; i < 18; i++) begin
      fifo_q.delete();
      pushWord(1'b1, 24'($urandom));
      idle(2);
      vsPulse();
      pixels(2);
      idle(1);
    end
    checkOutput("uf_sat", 32'(underflow_cnt), 32'(CNT_MAX));
    for (int i = 0; i < 18; i++) begin
      fifo_q.delete();
      pushWord(1'b1, 24'($urandom));
      pushWord(1'b0, 24'($urandom));
      idle(2);
      vsPulse();
      pixels(1);
      idle(1);
      vsPulse();
      pixels(1);
    end
    checkOutput("fe_sat", 32'(frame_err_cnt), 32'(CNT_MAX));
    checkOutput("uf_hold", 32'(underflow_cnt), 32'(CNT_MAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
